mc_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath. Replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB FSM

---
 rtl/mc_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle control sequencer for the MIPS datapath. A FETCH/DECODE/EXEC/
//   MEM/WB state machine drives the datapath enables and mux selects. A single
//   memory port is shared between instruction fetch and data access through a
//   req/ready handshake.
//   Supported: addu/add/subu/sub/and/or/slt, lw, sw, beq, bne, j, addiu.
//
// Parameters
//   MEM_TIMEOUT  cycles mem_req may wait for mem_ready before bus error
//                (0 = never time out)
//   CNT_W        width of the performance counters
//
// Optional feature
//   CTRL_PERF_CNT_EN  when defined, perf_cycles/perf_retired are real
//                     counters; otherwise both are tied to 0.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   instr_op/funct      IR[31:26] / IR[5:0], valid from DECODE onward
//   alu_zero            ALU zero flag (current cycle)
//   mem_ready           memory accepts/completes the access this cycle
//   mem_req/we/iord     memory request, write strobe, address select
//   ir_wen, pc_wen      IR and PC load enables
//   pc_src              0 = PC+4, 1 = branch target, 2 = jump target
//   alu_src_a/b, alu_ctrl  ALU operand selects and operation
//   rf_wen/dst/src      register file write controls
//   illegal             1-cycle pulse on undecodable instruction
//   bus_err             sticky memory timeout flag
//   state_o             current state (debug)
//   perf_cycles/retired performance counters
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instr_op,
  input  logic [5:0]       instr_funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_iord,
  output logic             ir_wen,
  output logic             pc_wen,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             rf_wen,
  output logic             rf_dst,
  output logic             rf_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDIU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_ILL
  } class_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  // Classify an op/funct pair into one of the supported instruction groups.
  function automatic class_t decodeClass(input logic [5:0] op, input logic [5:0] funct);
    class_t c;
    c = C_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001, 6'b100000, 6'b100011, 6'b100010,
          6'b100100, 6'b100101, 6'b101010: c = C_R;
          default:                         c = C_ILL;
        endcase
      end
      6'b001001: c = C_ADDIU;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000101: c = C_BNE;
      6'b000010: c = C_J;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  // ALU operation for R-type instructions, chosen by funct.
  function automatic logic [3:0] aluFromFunct(input logic [5:0] funct);
    logic [3:0] a;
    a = ALU_ADD;
    case (funct)
      6'b100011, 6'b100010: a = ALU_SUB;
      6'b100100:            a = ALU_AND;
      6'b100101:            a = ALU_OR;
      6'b101010:            a = ALU_SLT;
      default:              a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_op;
  logic [5:0]      r_funct;
  logic [TO_W-1:0] r_toCnt;
  logic            r_busErr;
  class_t          w_liveClass;
  class_t          w_latClass;
  logic            w_toHit;

  logic       w_memReq, w_memWe, w_memIord, w_irWen, w_pcWen;
  logic [1:0] w_pcSrc, w_aluSrcB;
  logic       w_aluSrcA, w_rfWen, w_rfDst, w_rfSrc, w_illegal;
  logic [3:0] w_aluCtrl;

  assign w_liveClass = decodeClass(instr_op, instr_funct);
  assign w_latClass  = decodeClass(r_op, r_funct);

  // The wait that would bring the counter up to MEM_TIMEOUT ends the access.
  assign w_toHit = (MEM_TIMEOUT != 0) && !mem_ready && (r_toCnt == TO_LAST);

  // State register, latched instruction fields, timeout counter and the
  // sticky bus error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_op     <= '0;
      r_funct  <= '0;
      r_toCnt  <= '0;
      r_busErr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= instr_op;
        r_funct <= instr_funct;
      end
      // Any state change clears the counter, so it starts from zero on
      // every entry to FETCH or MEM.
      if (r_state != w_next) begin
        r_toCnt <= '0;
      end else if (w_memReq && !mem_ready) begin
        r_toCnt <= r_toCnt + 1'b1;
      end
      if (r_state != S_HALT && w_next == S_HALT) begin
        r_busErr <= 1'b1;
      end
    end
  end

  // Next-state and control outputs.
  always_comb begin
    w_next    = r_state;
    w_memReq  = 1'b0;
    w_memWe   = 1'b0;
    w_memIord = 1'b0;
    w_irWen   = 1'b0;
    w_pcWen   = 1'b0;
    w_pcSrc   = 2'd0;
    w_aluSrcA = 1'b0;
    w_aluSrcB = 2'd0;
    w_aluCtrl = ALU_AND;
    w_rfWen   = 1'b0;
    w_rfDst   = 1'b0;
    w_rfSrc   = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memReq  = 1'b1;
        w_aluSrcB = 2'd1;
        w_aluCtrl = ALU_ADD;
        if (mem_ready) begin
          w_irWen = 1'b1;
          w_pcWen = 1'b1;
          w_next  = S_DECODE;
        end else if (w_toHit) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        w_aluSrcB = 2'd3;
        w_aluCtrl = ALU_ADD;
        if (w_liveClass == C_ILL) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_latClass)
          C_R: begin
            w_aluSrcA = 1'b1;
            w_aluCtrl = aluFromFunct(r_funct);
            w_next    = S_WB;
          end
          C_ADDIU: begin
            w_aluSrcA = 1'b1;
            w_aluSrcB = 2'd2;
            w_aluCtrl = ALU_ADD;
            w_next    = S_WB;
          end
          C_LW, C_SW: begin
            w_aluSrcA = 1'b1;
            w_aluSrcB = 2'd2;
            w_aluCtrl = ALU_ADD;
            w_next    = S_MEM;
          end
          C_BEQ, C_BNE: begin
            w_aluSrcA = 1'b1;
            w_aluCtrl = ALU_SUB;
            w_pcSrc   = 2'd1;
            w_pcWen   = (w_latClass == C_BEQ) ? alu_zero : !alu_zero;
            w_next    = S_FETCH;
          end
          C_J: begin
            w_pcSrc = 2'd2;
            w_pcWen = 1'b1;
            w_next  = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_memReq  = 1'b1;
        w_memIord = 1'b1;
        w_memWe   = (w_latClass == C_SW);
        if (mem_ready) begin
          w_next = (w_latClass == C_LW) ? S_WB : S_FETCH;
        end else if (w_toHit) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        w_rfWen = 1'b1;
        w_rfDst = (w_latClass == C_R);
        w_rfSrc = (w_latClass == C_LW);
        w_next  = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight access is
  // dropped immediately rather than at the next clock.
  assign mem_req   = !rst && w_memReq;
  assign mem_we    = !rst && w_memWe;
  assign mem_iord  = !rst && w_memIord;
  assign ir_wen    = !rst && w_irWen;
  assign pc_wen    = !rst && w_pcWen;
  assign pc_src    = rst ? 2'd0 : w_pcSrc;
  assign alu_src_a = !rst && w_aluSrcA;
  assign alu_src_b = rst ? 2'd0 : w_aluSrcB;
  assign alu_ctrl  = rst ? 4'd0 : w_aluCtrl;
  assign rf_wen    = !rst && w_rfWen;
  assign rf_dst    = !rst && w_rfDst;
  assign rf_src    = !rst && w_rfSrc;
  assign illegal   = !rst && w_illegal;
  assign bus_err   = !rst && r_busErr;
  assign state_o   = rst ? 3'd0 : r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_perfCycles;
  logic [CNT_W-1:0] r_perfRetired;
  logic             w_retire;

  // An instruction retires on the edge that returns to FETCH after doing
  // useful work; illegal NOPs leave from DECODE and are not counted.
  assign w_retire = (r_state == S_WB) ||
                    (r_state == S_EXEC && (w_latClass == C_BEQ || w_latClass == C_BNE ||
                                           w_latClass == C_J)) ||
                    (r_state == S_MEM && w_next == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfCycles  <= '0;
      r_perfRetired <= '0;
    end else begin
      if (r_state != S_HALT) begin
        r_perfCycles <= r_perfCycles + 1'b1;
      end
      if (w_retire) begin
        r_perfRetired <= r_perfRetired + 1'b1;
      end
    end
  end

  assign perf_cycles  = r_perfCycles;
  assign perf_retired = r_perfRetired;
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  localparam int CW = 32;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    instr_op, instr_funct;
  logic          alu_zero, mem_ready;
  logic          mem_req, mem_we, mem_iord, ir_wen, pc_wen;
  logic [1:0]    pc_src, alu_src_b;
  logic          alu_src_a;
  logic [3:0]    alu_ctrl;
  logic          rf_wen, rf_dst, rf_src, illegal, bus_err;
  logic [2:0]    state_o;
  logic [CW-1:0] perf_cycles, perf_retired;

  int checks = 0;
  int errors = 0;
  int expRetired = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .instr_op(instr_op), .instr_funct(instr_funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_iord(mem_iord),
    .ir_wen(ir_wen), .pc_wen(pc_wen), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .rf_wen(rf_wen), .rf_dst(rf_dst), .rf_src(rf_src),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o),
    .perf_cycles(perf_cycles), .perf_retired(perf_retired)
  );

  task automatic applyStimulus(input logic ready, input logic zero,
                               input logic [5:0] op, input logic [5:0] funct);
    mem_ready   = ready;
    alu_zero    = zero;
    instr_op    = op;
    instr_funct = funct;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait FETCH cycle; IR bits are scrambled to show they are not used yet.
  task automatic doFetch(input string tag);
    applyStimulus(1'b1, 1'b0, 6'h3f, 6'h3f);
    checkOutput({tag, "_fetchState"}, 32'(state_o), 0);
    checkOutput({tag, "_irWen"}, 32'(ir_wen), 1);
    checkOutput({tag, "_pcWen"}, 32'(pc_wen), 1);
    tick();
  endtask

  // Full R-type instruction from FETCH back to FETCH.
  task automatic runRtype(input string tag, input logic [5:0] funct, input logic [3:0] expAlu);
    doFetch(tag);
    applyStimulus(1'b1, 1'b0, 6'b000000, funct);
    checkOutput({tag, "_decState"}, 32'(state_o), 1);
    checkOutput({tag, "_decSrcB"}, 32'(alu_src_b), 3);
    checkOutput({tag, "_decIllegal"}, 32'(illegal), 0);
    tick();
    applyStimulus(1'b1, 1'b0, 6'b111111, 6'b000000);
    checkOutput({tag, "_exState"}, 32'(state_o), 2);
    checkOutput({tag, "_exAlu"}, 32'(alu_ctrl), 32'(expAlu));
    checkOutput({tag, "_exSrcA"}, 32'(alu_src_a), 1);
    checkOutput({tag, "_exSrcB"}, 32'(alu_src_b), 0);
    tick();
    checkOutput({tag, "_wbState"}, 32'(state_o), 4);
    checkOutput({tag, "_wbRfWen"}, 32'(rf_wen), 1);
    checkOutput({tag, "_wbRfDst"}, 32'(rf_dst), 1);
    checkOutput({tag, "_wbRfSrc"}, 32'(rf_src), 0);
    tick();
    expRetired++;
    checkOutput({tag, "_backFetch"}, 32'(state_o), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset: everything low while rst is high.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'h00, 6'h00);
    checkOutput("rstMemReq", 32'(mem_req), 0);
    checkOutput("rstState", 32'(state_o), 0);
    checkOutput("rstBusErr", 32'(bus_err), 0);
    checkOutput("rstSrcB", 32'(alu_src_b), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // FETCH waiting on memory: request held, no loads.
    checkOutput("fetchReq", 32'(mem_req), 1);
    checkOutput("fetchIord", 32'(mem_iord), 0);
    checkOutput("fetchSrcB", 32'(alu_src_b), 1);
    checkOutput("fetchAlu", 32'(alu_ctrl), 32'h2);
    checkOutput("fetchIrHold", 32'(ir_wen), 0);

    // R-type group.
    runRtype("addu", 6'b100001, 4'b0010);
    runRtype("sub", 6'b100010, 4'b0110);
    runRtype("slt", 6'b101010, 4'b0111);
    runRtype("or", 6'b100101, 4'b0001);

    // lw with two memory wait cycles: F D E M M M W = 7 cycles.
    doFetch("lw");
    applyStimulus(1'b1, 1'b0, 6'b100011, 6'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 6'b000000, 6'h00);
    checkOutput("lwExSrcB", 32'(alu_src_b), 2);
    checkOutput("lwExAlu", 32'(alu_ctrl), 32'h2);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 6'b000000, 6'h00);
      checkOutput("lwMemState", 32'(state_o), 3);
      checkOutput("lwMemReq", 32'(mem_req), 1);
      checkOutput("lwMemIord", 32'(mem_iord), 1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 6'b000000, 6'h00);
    checkOutput("lwMemReqLast", 32'(mem_req), 1);
    checkOutput("lwMemWe", 32'(mem_we), 0);
    tick();
    checkOutput("lwWbState", 32'(state_o), 4);
    checkOutput("lwWbRfSrc", 32'(rf_src), 1);
    checkOutput("lwWbRfDst", 32'(rf_dst), 0);
    tick();
    expRetired++;
    checkOutput("lwDone", 32'(state_o), 0);

    // sw zero-wait.
    doFetch("sw");
    applyStimulus(1'b1, 1'b0, 6'b101011, 6'h00);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 6'b000000, 6'h00);
    checkOutput("swMemState", 32'(state_o), 3);
    checkOutput("swMemWe", 32'(mem_we), 1);
    tick();
    expRetired++;
    checkOutput("swDone", 32'(state_o), 0);

    // beq taken.
    doFetch("beq");
    applyStimulus(1'b1, 1'b0, 6'b000100, 6'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 6'b000000, 6'h00);
    checkOutput("beqPcWen", 32'(pc_wen), 1);
    checkOutput("beqPcSrc", 32'(pc_src), 1);
    checkOutput("beqAlu", 32'(alu_ctrl), 32'h6);
    tick();
    expRetired++;
    checkOutput("beqDone", 32'(state_o), 0);

    // bne with zero set: not taken, still retires.
    doFetch("bne");
    applyStimulus(1'b1, 1'b0, 6'b000101, 6'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 6'b000000, 6'h00);
    checkOutput("bneZeroPcWen", 32'(pc_wen), 0);
    applyStimulus(1'b1, 1'b0, 6'b000000, 6'h00);
    checkOutput("bneNzPcWen", 32'(pc_wen), 1);
    tick();
    expRetired++;
    checkOutput("bneDone", 32'(state_o), 0);

    // addiu.
    doFetch("addiu");
    applyStimulus(1'b1, 1'b0, 6'b001001, 6'h00);
    tick();
    checkOutput("addiuSrcB", 32'(alu_src_b), 2);
    checkOutput("addiuExState", 32'(state_o), 2);
    tick();
    checkOutput("addiuWbRfWen", 32'(rf_wen), 1);
    checkOutput("addiuWbRfDst", 32'(rf_dst), 0);
    checkOutput("addiuWbRfSrc", 32'(rf_src), 0);
    tick();
    expRetired++;

    // Three FETCH wait cycles stay below the timeout; then a jump.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 6'h00, 6'h00);
      checkOutput("waitFetchState", 32'(state_o), 0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 6'h00, 6'h00);
    checkOutput("waitIrWen", 32'(ir_wen), 1);
    checkOutput("waitNoBusErr", 32'(bus_err), 0);
    tick();
    applyStimulus(1'b1, 1'b0, 6'b000010, 6'h00);
    checkOutput("jDecState", 32'(state_o), 1);
    tick();
    checkOutput("jPcSrc", 32'(pc_src), 2);
    checkOutput("jPcWen", 32'(pc_wen), 1);
    tick();
    expRetired++;
    checkOutput("jDone", 32'(state_o), 0);

    // Illegal opcode, then illegal R funct.
    doFetch("ill");
    applyStimulus(1'b1, 1'b0, 6'b111111, 6'h00);
    checkOutput("illPulse", 32'(illegal), 1);
    tick();
    checkOutput("illNextState", 32'(state_o), 0);
    checkOutput("illCleared", 32'(illegal), 0);
    doFetch("illF");
    applyStimulus(1'b1, 1'b0, 6'b000000, 6'b000000);
    checkOutput("illFunctPulse", 32'(illegal), 1);
    tick();
    checkOutput("illFunctNext", 32'(state_o), 0);
    checkOutput("perfRetired", perf_retired, PERF ? 32'(expRetired) : 32'd0);

    // Timeout in FETCH: fourth wait cycle ends in HALT.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 6'h00, 6'h00);
      tick();
      checkOutput("toNotYet", 32'(state_o), 0);
    end
    tick();
    checkOutput("toHalt", 32'(state_o), 7);
    checkOutput("toBusErr", 32'(bus_err), 1);
    checkOutput("toMemReq", 32'(mem_req), 0);
    applyStimulus(1'b1, 1'b0, 6'h00, 6'h00);
    tick();
    checkOutput("haltStays", 32'(state_o), 7);
    checkOutput("haltPcWen", 32'(pc_wen), 0);
    rst = 1'b1;
    #1;
    checkOutput("toRstState", 32'(state_o), 0);
    checkOutput("toRstBusErr", 32'(bus_err), 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("afterRstBusErr", 32'(bus_err), 0);

    // Reset mid-MEM of sw drops the strobes without waiting for a clock.
    doFetch("swRst");
    applyStimulus(1'b1, 1'b0, 6'b101011, 6'h00);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 6'b000000, 6'h00);
    checkOutput("swRstReqBefore", 32'(mem_req), 1);
    checkOutput("swRstWeBefore", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    checkOutput("swRstReq", 32'(mem_req), 0);
    checkOutput("swRstWe", 32'(mem_we), 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("perfCyc0", perf_cycles, 0);
    checkOutput("perfRet0", perf_retired, 0);
    tick();
    checkOutput("perfCyc1", perf_cycles, PERF ? 32'd1 : 32'd0);
    tick();
    checkOutput("perfCyc2", perf_cycles, PERF ? 32'd2 : 32'd0);
    checkOutput("postRstState", 32'(state_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
